// File: rtl/tap_delay_pkg.sv
// Shared constants and helpers for the tap delay line: delay clamping and field width.
// No logic of its own; imported by the interface, the stage and the top.
package tap_delay_pkg;

  localparam int unsigned DELAY_MIN = 1;

  // Width needed to hold 0..max_delay inclusive
  function automatic int unsigned delay_width(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned delay, input int unsigned max_delay);
    if (delay < DELAY_MIN) return DELAY_MIN;
    if (delay > max_delay) return max_delay;
    return delay;
  endfunction

endpackage

// File: rtl/tap_delay_line_if.sv
// Sample/tap bundle between the source (master) and the delay line (slave).
// o_occupancy exists only when TAP_DELAY_OCC_EN is defined.
interface tap_delay_line_if
  import tap_delay_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned MAX_DELAY = 8
);
  localparam int unsigned DW = delay_width(MAX_DELAY);

  logic                      i_en;
  logic                      i_flush;
  logic                      i_valid;
  logic [CHANNELS*WIDTH-1:0] i_data;
  logic [DW-1:0]             i_delay;
  logic [CHANNELS*WIDTH-1:0] o_data;
  logic                      o_valid;
  logic                      o_primed;
`ifdef TAP_DELAY_OCC_EN
  logic [DW-1:0]             o_occupancy;

  modport master (output i_en, i_flush, i_valid, i_data, i_delay,
                  input  o_data, o_valid, o_primed, o_occupancy);
  modport slave  (input  i_en, i_flush, i_valid, i_data, i_delay,
                  output o_data, o_valid, o_primed, o_occupancy);
`else
  modport master (output i_en, i_flush, i_valid, i_data, i_delay,
                  input  o_data, o_valid, o_primed);
  modport slave  (input  i_en, i_flush, i_valid, i_data, i_delay,
                  output o_data, o_valid, o_primed);
`endif

endinterface

// File: rtl/tap_delay_stage.sv
// One {valid, data} register of the delay line; loads on en, flush clears only valid.
// Latency 1 enabled cycle; holds everything while en=0.
module tap_delay_stage
  import tap_delay_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         d_valid,
  input  logic [W-1:0] d_data,
  output logic         q_valid,
  output logic [W-1:0] q_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    // Flush has priority; data is deliberately left stale
    if (flush) begin
      valid_d = 1'b0;
    end else if (en) begin
      valid_d = d_valid;
      data_d  = d_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q_data  = data_q;

endmodule

// File: rtl/tap_delay_line.sv
// Multi-channel delay line, output tapped at clamp(i_delay,1,MAX_DELAY) enabled cycles; stalls on i_en=0.
// Define TAP_DELAY_OCC_EN to add the o_occupancy count of valid stages.
module tap_delay_line
  import tap_delay_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned MAX_DELAY = 8
) (
  input logic              clk,
  input logic              rst,
  tap_delay_line_if.slave  bus
);

  localparam int unsigned DW     = delay_width(MAX_DELAY);
  localparam int unsigned DATA_W = CHANNELS * WIDTH;

  logic [DATA_W-1:0] src_data    [MAX_DELAY];
  logic              src_valid   [MAX_DELAY];
  logic [DATA_W-1:0] stage_data  [MAX_DELAY];
  logic              stage_valid [MAX_DELAY];

  always_comb begin
    src_data[0]  = bus.i_data;
    src_valid[0] = bus.i_valid;
    for (int k = 1; k < int'(MAX_DELAY); k++) begin
      src_data[k]  = stage_data[k-1];
      src_valid[k] = stage_valid[k-1];
    end
  end

  for (genvar k = 0; k < int'(MAX_DELAY); k++) begin : g_stage
    tap_delay_stage #(.W(DATA_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.i_en),
      .flush   (bus.i_flush),
      .d_valid (src_valid[k]),
      .d_data  (src_data[k]),
      .q_valid (stage_valid[k]),
      .q_data  (stage_data[k])
    );
  end

  logic [DW-1:0] eff_delay;
  assign eff_delay = DW'(clamp_delay(32'(bus.i_delay), MAX_DELAY));

  // Tap select by compare rather than index keeps the mux width-exact
  logic [DATA_W-1:0] tap_data;
  logic              tap_valid;
  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int k = 0; k < int'(MAX_DELAY); k++) begin
      if (eff_delay == DW'(k + 1)) begin
        tap_data  = stage_data[k];
        tap_valid = stage_valid[k];
      end
    end
  end

  logic [DW-1:0] count_q, count_d;
  always_comb begin
    count_d = count_q;
    if (bus.i_flush) begin
      count_d = '0;
    end else if (bus.i_en && (count_q != DW'(MAX_DELAY))) begin
      count_d = count_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign bus.o_data   = tap_data;
  assign bus.o_valid  = tap_valid;
  assign bus.o_primed = (count_q >= eff_delay);

`ifdef TAP_DELAY_OCC_EN
  logic [DW-1:0] occ_q, occ_d;
  always_comb begin
    occ_d = occ_q;
    if (bus.i_flush) begin
      occ_d = '0;
    end else if (bus.i_en) begin
      case ({bus.i_valid, stage_valid[MAX_DELAY-1]})
        2'b10:   occ_d = occ_q + DW'(1);
        2'b01:   occ_d = occ_q - DW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign bus.o_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line (WIDTH=8, CHANNELS=2, MAX_DELAY=8): vector table plus scoreboard.
// Occupancy checks run only when TAP_DELAY_OCC_EN is defined.
module tb_tap_delay_line;

  logic clk;
  logic rst;

  tap_delay_line_if #(.WIDTH(8), .CHANNELS(2), .MAX_DELAY(8)) bus ();

  tap_delay_line #(.WIDTH(8), .CHANNELS(2), .MAX_DELAY(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        v;
    logic [15:0] d;
    logic [3:0]  dly;
    logic        ev;
    logic [15:0] ed;
    logic        ep;
  } vec_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    int          due;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  int   adv = 0;
  logic [3:0] cur_delay = 4'd0;
  sb_t  sbq[$];
  vec_t tbl[16];

  task automatic checkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the given inputs; scoreboard pushes accepted samples and
  // pops each one on the advance that brings it to the selected tap.
  task automatic drive(input logic en, input logic fl, input logic v,
                       input logic [15:0] d, input logic [3:0] dly);
    int  eff;
    sb_t e;
    eff = (dly == 4'd0) ? 1 : ((dly > 4'd8) ? 8 : int'(dly));
    if (dly != cur_delay) sbq.delete();
    cur_delay   = dly;
    bus.i_en    = en;
    bus.i_flush = fl;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_delay = dly;
    @(posedge clk);
    #1;
    if (fl) begin
      sbq.delete();
    end else if (en) begin
      adv++;
      sbq.push_back('{v: v, d: d, due: adv + eff - 1});
      if (sbq.size() > 0 && sbq[0].due == adv) begin
        e = sbq.pop_front();
        checkb("sb_valid", bus.o_valid, e.v);
        if (e.v) checkw("sb_data", bus.o_data, e.d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 16'h0102, 4'd3, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 16'h0304, 4'd3, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'h0506, 4'd3, 1'b1, 16'h0102, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 4'd3, 1'b1, 16'h0304, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 4'd3, 1'b1, 16'h0506, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 4'd3, 1'b0, 16'h0000, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'h1111, 4'd2, 1'b0, 16'h0000, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 16'h0000, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 16'h0000, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 16'h0000, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 4'd2, 1'b0, 16'h0000, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 16'h0000, 4'd2, 1'b1, 16'h1111, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 16'h0000, 4'd2, 1'b0, 16'h0000, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 16'h00AB, 4'd0, 1'b1, 16'h00AB, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 16'h00CD, 4'd0, 1'b1, 16'h00AB, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0000, 1'b1};

    // Reset held with the line enabled and data presented
    rst         = 1'b0;
    bus.i_en    = 1'b1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = 16'hA5A5;
    bus.i_delay = 4'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkw("rst_data", bus.o_data, 16'h0000);
      checkb("rst_valid", bus.o_valid, 1'b0);
      checkb("rst_primed", bus.o_primed, 1'b0);
    end
    bus.i_en = 1'b0;
    rst      = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      bus.i_delay = 4'(k);
      #1;
      checkb("empty_valid", bus.o_valid, 1'b0);
      checkw("empty_data", bus.o_data, 16'h0000);
    end
`ifdef TAP_DELAY_OCC_EN
    checkw("rst_occ", 16'(bus.o_occupancy), 16'h0000);
`endif

    // Table: basic delay 3, stall at delay 2, clamp of delay 0
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 4'd3);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, 1'b0, tbl[i].v, tbl[i].d, tbl[i].dly);
      checkb($sformatf("tbl%0d_valid", i), bus.o_valid, tbl[i].ev);
      if (tbl[i].ev) checkw($sformatf("tbl%0d_data", i), bus.o_data, tbl[i].ed);
      checkb($sformatf("tbl%0d_primed", i), bus.o_primed, tbl[i].ep);
    end

    // Delay 15 clamps to 8: primed and first sample only after 8th advance
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 4'd15);
    checkb("flush_primed", bus.o_primed, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 16'h2000 + 16'(i), 4'd15);
      checkb($sformatf("clamp8_primed%0d", i), bus.o_primed, i == 7);
      checkb($sformatf("clamp8_valid%0d", i), bus.o_valid, i == 7);
    end
`ifdef TAP_DELAY_OCC_EN
    checkw("full_occ", 16'(bus.o_occupancy), 16'd8);
`endif

    // Flush collides with an enabled valid sample: it must never emerge
    drive(1'b1, 1'b1, 1'b1, 16'h7777, 4'd15);
    checkb("flush_col_valid", bus.o_valid, 1'b0);
    checkb("flush_col_primed", bus.o_primed, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 4'd15);
      for (int k = 1; k <= 8; k++) begin
        bus.i_delay = 4'(k);
        #1;
        checkb("no_7777_valid", bus.o_valid, 1'b0);
      end
      bus.i_delay = 4'd15;
    end

`ifdef TAP_DELAY_OCC_EN
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 4'd8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, (i % 2) == 0, 16'h3000 + 16'(i), 4'd8);
    end
    checkw("alt_occ", 16'(bus.o_occupancy), 16'd4);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 4'd8);
    checkw("flush_occ", 16'(bus.o_occupancy), 16'd0);
`endif

    // Asynchronous reset mid-cycle clears the tap at once
    drive(1'b1, 1'b0, 1'b1, 16'h4242, 4'd1);
    drive(1'b1, 1'b0, 1'b1, 16'h4343, 4'd1);
    checkb("pre_arst_primed", bus.o_primed, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkb("arst_valid", bus.o_valid, 1'b0);
    checkw("arst_data", bus.o_data, 16'h0000);
    checkb("arst_primed", bus.o_primed, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_delay_line.md
Name: tap_delay_line

Overview:
- Multi-channel, runtime-selectable delay line. Generalises the fixed-depth shift FIFO with its warm-up counter.
- Each stage holds `CHANNELS` words plus a valid bit. The line advances only on `i_en`.
- The output is taken from a tap chosen at run time. Valid bits travel with the data, and a primed flag reports when the selected depth has filled.
- Sits between the sample source and downstream alignment logic, where channels must be skewed by a programmable number of enabled cycles.

Parameters:
- WIDTH, 8, bits per channel word
- CHANNELS, 2, number of parallel channels delayed in lockstep
- MAX_DELAY, 8, number of register stages (maximum delay); legal range 1..64
- DW, $clog2(MAX_DELAY+1), derived, width of the delay/count fields; not overridable

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- i_en  input  1  advance the line this cycle
- i_flush  input  1  synchronous clear of valid bits and warm-up count
- i_valid  input  1  qualifies i_data; sampled only when i_en=1
- i_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- i_delay  input  DW  selected delay in enabled cycles
- o_data  output  CHANNELS*WIDTH  data at the selected tap
- o_valid  output  1  valid bit at the selected tap
- o_primed  output  1  at least eff_delay advances since last reset/flush

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage data and valid bits clear to 0.
  - Warm-up count clears to 0.
  - o_data=0, o_valid=0, o_primed=0.
- Effective delay:
  - eff_delay = clamp(i_delay, 1, MAX_DELAY): 0 is treated as 1, and values above MAX_DELAY as MAX_DELAY.
  - There is no zero-latency bypass.
- Stages: stage[0..MAX_DELAY-1]. When i_en=1 and i_flush=0, on the clock edge:
  - stage[0] <= {i_valid, i_data}
  - stage[k] <= stage[k-1] for k≥1
- When i_en=0 all stages hold, including valid bits.
- Output is combinational from registers:
  - o_data/o_valid = stage[eff_delay-1].
  - Latency from an accepted input to o_valid is exactly eff_delay enabled cycles; idle cycles do not count.
- Warm-up count:
  - Increments on each advance and saturates at MAX_DELAY.
  - o_primed = (count ≥ eff_delay), combinational.
- Flush (i_flush=1 on a clock edge):
  - All valid bits clear and count clears to 0. Data registers are left as-is.
  - Flush wins over a simultaneous i_en; the incoming sample is dropped.
  - From the next cycle: o_valid=0, o_primed=0.
- Changing i_delay mid-stream:
  - Takes effect the same cycle with no flush; the output re-taps the existing contents.
  - Lowering the delay can re-emit samples. Raising it can expose older or invalid stages; o_valid reflects the stored bit.
  - o_primed is re-evaluated against the new eff_delay.
- Async reset asserted mid-operation clears everything immediately. Deassertion is synchronised externally.
- Channels never interact; all share one valid bit per stage.

Optional Feature:
- Macro `TAP_DELAY_OCC_EN`.
- Defined:
  - Adds output port o_occupancy, width DW: the number of stages with valid=1.
  - Held in a register and updated incrementally on each advance: +1 if the entering valid is 1, −1 if the valid shifted out of stage[MAX_DELAY-1] is 1.
  - Zeroed on flush and reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package tap_delay_pkg holds:
  - function clamp_delay(delay, max), returning a value in 1..max
  - localparam-style helper for the DW computation
  - constant DELAY_MIN=1
- Sub-module tap_delay_stage:
  - One register stage of {valid, CHANNELS*WIDTH data} with en, flush and async active-low reset.
  - Instantiated MAX_DELAY times via a generate loop.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_en=1 and i_data=0xA5A5 → o_data=0, o_valid=0, o_primed=0 throughout. After release, the line is empty.
- Basic delay (i_delay=3, i_en=1 constant): drive i_valid=1 with data 0x0102, 0x0304, 0x0506 on cycles 0..2.
  - o_valid rises at cycle 3 with o_data=0x0102, then 0x0304, 0x0506.
  - o_primed=1 from cycle 3.
- Stall: i_delay=2. Drive 0x1111, then i_en=0 for 4 cycles, then i_en=1.
  - 0x1111 appears only after the 2nd enabled cycle.
  - o_data holds steady during the stall.
- Clamp: i_delay=0 → behaves as delay 1. i_delay=15 with MAX_DELAY=8 → behaves as delay 8, and o_primed rises after the 8th advance.
- Flush collision: line full of valid data, i_flush=1 and i_en=1 with i_data=0x7777 → next cycle o_valid=0 and o_primed=0. 0x7777 never emerges with valid=1.
- Occupancy (`TAP_DELAY_OCC_EN`): alternate i_valid 1/0 for 8 enabled cycles with MAX_DELAY=8 → o_occupancy=4; one flush → 0.
